// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation controller: FSM states,
// pump register address/data encodings and the tick-counter helper.
package irrigation_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PUMPING  = 2'd1,
    S_COOLDOWN = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  localparam logic [1:0] PUMP_ADDR = 2'b00;
  localparam logic [7:0] PUMP_ON   = 8'h01;
  localparam logic [7:0] PUMP_OFF  = 8'h00;

  localparam int TCNT_W = 16;

  // Saturating increment so long dwell times never wrap back below a threshold.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 and pulses tick in the cycle
// the counter wraps.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/irrigation_controller.sv
// Hysteresis moisture controller driving the pump wrapper's register port.
// Define IRRIG_DRYRUN_GUARD_EN to add the MAX_ON_TICKS dry-run fault state.
module irrigation_controller
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV       = 1000,
  parameter int MIN_ON_TICKS   = 10,
  parameter int MAX_ON_TICKS   = 200,
  parameter int COOLDOWN_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] moisture,
  input  logic       moisture_valid,
  input  logic [7:0] low_thr,
  input  logic [7:0] high_thr,
  input  logic       fault_clr,
  output logic       write,
  output logic [1:0] address,
  output logic [7:0] dataOut,
  output logic       pump_cmd,
  output logic       fault
);

  state_t              r_state, w_next;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_write, r_pump, r_fault;
  logic [7:0]          r_data;
  logic                w_write, w_pump, w_fault;
  logic [7:0]          w_data;
  logic                w_tick, w_start, w_stop, w_maxon, w_fclr;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_start = moisture_valid && (moisture < low_thr);
  // Early stop samples simply fail this test; nothing is remembered.
  assign w_stop  = moisture_valid && (moisture >= high_thr) &&
                   (r_tcnt >= TCNT_W'(MIN_ON_TICKS));

`ifdef IRRIG_DRYRUN_GUARD_EN
  assign w_maxon = (r_tcnt >= TCNT_W'(MAX_ON_TICKS));
  assign w_fclr  = fault_clr;
`else
  logic w_unused_guard;
  assign w_maxon        = 1'b0;
  assign w_fclr         = 1'b0;
  assign w_unused_guard = fault_clr ^ (MAX_ON_TICKS != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next = S_PUMPING;
      // Dry-run limit takes priority over a simultaneous moisture stop.
      S_PUMPING:  if (w_maxon) w_next = S_FAULT;
                  else if (w_stop) w_next = S_COOLDOWN;
      S_COOLDOWN: if (r_tcnt >= TCNT_W'(COOLDOWN_TICKS)) w_next = S_IDLE;
      S_FAULT:    if (w_fclr) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_write = 1'b0;
    w_data  = r_data;
    w_pump  = r_pump;
    w_fault = r_fault;
    if (w_next != r_state) begin
      case (w_next)
        S_PUMPING:  begin w_write = 1'b1; w_data = PUMP_ON;  w_pump = 1'b1; end
        S_COOLDOWN: begin w_write = 1'b1; w_data = PUMP_OFF; w_pump = 1'b0; end
        S_FAULT:    begin w_write = 1'b1; w_data = PUMP_OFF; w_pump = 1'b0; w_fault = 1'b1; end
        S_IDLE:     w_fault = 1'b0;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt  <= '0;
      r_write <= 1'b0;
      r_data  <= PUMP_OFF;
      r_pump  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_next != r_state) r_tcnt <= '0;
      else if (w_tick)       r_tcnt <= sat_inc(r_tcnt);
      r_write <= w_write;
      r_data  <= w_data;
      r_pump  <= w_pump;
      r_fault <= w_fault;
    end
  end

  assign write    = r_write;
  assign address  = PUMP_ADDR;
  assign dataOut  = r_data;
  assign pump_cmd = r_pump;
  assign fault    = r_fault;

endmodule

// File: tb/tb_irrigation_controller.sv
// Bench for irrigation_controller: fixed vector table, hand-written corner
// sequences and random stimulus, all checked against a cycle-count model.
module tb_irrigation_controller;

  localparam int D     = 4;
  localparam int MINON = 3;
  localparam int MAXON = 10;
  localparam int COOL  = 2;
`ifdef IRRIG_DRYRUN_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] moisture, low_thr, high_thr;
  logic       moisture_valid, fault_clr;
  logic       write, pump_cmd, fault;
  logic [1:0] address;
  logic [7:0] dataOut;

  always #5 clk = ~clk;

  irrigation_controller #(
    .TICK_DIV(D), .MIN_ON_TICKS(MINON), .MAX_ON_TICKS(MAXON), .COOLDOWN_TICKS(COOL)
  ) dut (
    .clk(clk), .rst(rst), .moisture(moisture), .moisture_valid(moisture_valid),
    .low_thr(low_thr), .high_thr(high_thr), .fault_clr(fault_clr),
    .write(write), .address(address), .dataOut(dataOut),
    .pump_cmd(pump_cmd), .fault(fault)
  );

  // Reference model: ticks elapsed are derived from absolute edge numbers
  // (a tick falls on every edge whose index mod D is D-1).
  typedef enum {M_IDLE, M_PUMP, M_COOL, M_FAULT} mst_t;
  mst_t       m_st;
  int         m_c, m_entry;
  logic       m_write, m_pump, m_fault;
  logic [7:0] m_data;

  function automatic int ticks_since(int now, int entry);
    return now / D - (entry + 1) / D;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= M_IDLE; m_c <= 0; m_entry <= 0;
      m_write <= 1'b0; m_data <= 8'h00; m_pump <= 1'b0; m_fault <= 1'b0;
    end else begin
      m_c     <= m_c + 1;
      m_write <= 1'b0;
      case (m_st)
        M_IDLE: if (moisture_valid && moisture < low_thr) begin
          m_st <= M_PUMP; m_entry <= m_c; m_write <= 1'b1; m_data <= 8'h01; m_pump <= 1'b1;
        end
        M_PUMP: if (GUARD && ticks_since(m_c, m_entry) >= MAXON) begin
          m_st <= M_FAULT; m_entry <= m_c; m_write <= 1'b1; m_data <= 8'h00;
          m_pump <= 1'b0; m_fault <= 1'b1;
        end else if (moisture_valid && moisture >= high_thr &&
                     ticks_since(m_c, m_entry) >= MINON) begin
          m_st <= M_COOL; m_entry <= m_c; m_write <= 1'b1; m_data <= 8'h00; m_pump <= 1'b0;
        end
        M_COOL: if (ticks_since(m_c, m_entry) >= COOL) begin
          m_st <= M_IDLE; m_entry <= m_c;
        end
        M_FAULT: if (fault_clr) begin
          m_st <= M_IDLE; m_entry <= m_c; m_fault <= 1'b0;
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("sb_write", write, m_write);
    chk("sb_addr",  address, 2'b00);
    chk("sb_data",  dataOut, m_data);
    chk("sb_pump",  pump_cmd, m_pump);
    chk("sb_fault", fault, m_fault);
  endtask

  typedef struct {
    int         gap;
    logic [7:0] m;
    logic       w;
    logic [7:0] d;
    logic       p;
  } vec_t;

  vec_t vt[10];

  task automatic sample(input logic [7:0] m);
    cyc();
    moisture = m; moisture_valid = 1'b1;
    cyc();
    moisture_valid = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; moisture = 8'd0; moisture_valid = 1'b0; fault_clr = 1'b0;
    low_thr = 8'd40; high_thr = 8'd80;

    // Edge distance between consecutive samples is gap+2 cycles.
    vt[0] = '{2,  8'd60, 1'b0, 8'h00, 1'b0};
    vt[1] = '{2,  8'd30, 1'b1, 8'h01, 1'b1};
    vt[2] = '{2,  8'd90, 1'b0, 8'h01, 1'b1};
    vt[3] = '{14, 8'd90, 1'b1, 8'h00, 1'b0};
    vt[4] = '{0,  8'd10, 1'b0, 8'h00, 1'b0};
    vt[5] = '{14, 8'd10, 1'b1, 8'h01, 1'b1};
    vt[6] = '{14, 8'd80, 1'b1, 8'h00, 1'b0};
    vt[7] = '{14, 8'd40, 1'b0, 8'h00, 1'b0};
    vt[8] = '{0,  8'd39, 1'b1, 8'h01, 1'b1};
    vt[9] = '{14, 8'd79, 1'b0, 8'h01, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_write", write, 1'b0);
    chk("rst_addr",  address, 2'b00);
    chk("rst_data",  dataOut, 8'h00);
    chk("rst_pump",  pump_cmd, 1'b0);
    chk("rst_fault", fault, 1'b0);

    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < vt[i].gap; g++) begin
        cyc();
        chk("gap_write", write, 1'b0);
      end
      sample(vt[i].m);
      chk($sformatf("vec%0d_write", i), write, vt[i].w);
      chk($sformatf("vec%0d_data", i), dataOut, vt[i].d);
      chk($sformatf("vec%0d_pump", i), pump_cmd, vt[i].p);
    end

    // Reset while pumping: outputs drop asynchronously, no off-write after.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pump",  pump_cmd, 1'b0);
    chk("midrst_write", write, 1'b0);
    chk("midrst_data",  dataOut, 8'h00);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample(8'd60);
      chk("postrst_nowrite", write, 1'b0);
    end
    sample(8'd30);
    chk("postrst_start_w", write, 1'b1);
    chk("postrst_start_d", dataOut, 8'h01);

`ifdef IRRIG_DRYRUN_GUARD_EN
    // Keep the soil dry until the dry-run limit trips.
    cyc();
    moisture = 8'd30; moisture_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      cyc();
      if (write) found = 1'b1;
    end
    chk("maxon_seen",  found, 1'b1);
    chk("maxon_data",  dataOut, 8'h00);
    chk("maxon_fault", fault, 1'b1);
    chk("maxon_pump",  pump_cmd, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fault_ignores", write, 1'b0);
    end
    moisture_valid = 1'b0; fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    chk("fclr_fault", fault, 1'b0);
    sample(8'd30);
    chk("fclr_restart", write, 1'b1);
`endif

    for (int k = 0; k < 3000; k++) begin
      cyc();
      if (k % 500 == 0 && k != 0) begin
        low_thr  = 8'($urandom_range(0, 255));
        high_thr = 8'($urandom_range(0, 255));
      end
      rst            = ($urandom_range(0, 399) == 0);
      moisture       = 8'($urandom_range(0, 255));
      moisture_valid = ($urandom_range(0, 2) == 0);
      fault_clr      = ($urandom_range(0, 15) == 0);
    end
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
